// File: rtl/expr_cov_monitor.sv
// expr_cov_monitor
//   Expression/condition coverage collector for an N_IN-input reduction
//   expression (OR when MODE=0, AND when MODE=1). Each evaluated sample is
//   classified into a bin. Saturating counters hold the bins, and a
//   valid/ready port drains them.
//
//   Bins: 0..N_IN-1  input i alone at the controlling value
//         N_IN       all inputs non-controlling
//         N_IN+1     any input X/Z
//         N_IN+2     total evaluations
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sample_en        qualifies in_vec this cycle
//   in_vec[N_IN]     expression inputs (4-state)
//   clr              synchronous clear of counters, sat_flag and history (IDLE only)
//   dump_req         starts a counter dump
//   expr_out         registered result of the last evaluated sample
//   busy             high while dumping
//   rd_valid/rd_ready, rd_idx, rd_data   dump beat handshake
//   dump_done        one-cycle pulse after the last beat is accepted
//   sat_flag         sticky, set when an increment hits an all-ones counter
//   dbg_state        current FSM state (0 = IDLE, 1 = DUMP)
//
// Handshake: a beat transfers on a rising edge where rd_valid && rd_ready;
// while rd_ready is low, rd_idx/rd_data/rd_valid stay unchanged.
module expr_cov_monitor #(
  parameter int N_IN          = 2,   // legal range 2..16
  parameter int MODE          = 0,
  parameter int CNT_W         = 16,
  parameter int CHANGE_ONLY   = 1,
  parameter int CLEAR_ON_DUMP = 0,
  localparam int NB           = N_IN + 3,
  localparam int IDX_W        = $clog2(N_IN + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             clr,
  input  logic             dump_req,
  output logic             expr_out,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             dump_done,
  output logic             sat_flag,
  output logic             dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_DUMP = 1'b1} state_t;

  state_t           state_q;
  logic             busy_q;
  logic             rd_valid_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             dump_done_q;
  logic             sat_q;
  logic             expr_q;
  logic             hist_q;
  logic [CNT_W-1:0] cnt_q [NB];

  logic             expr_d;
  logic [N_IN-1:0]  ctrl_vec;
  logic             unknown_in;
  logic [NB-1:0]    bin_hit;
  logic             clr_en;
  logic             eval_en;
  logic             accept;

  // Reduction result keeps 4-state semantics: 1|x = 1 and 0&x = 0.
  assign expr_d     = (MODE != 0) ? (&in_vec) : (|in_vec);
  // A bit in ctrl_vec is set where the input holds the controlling value.
  assign ctrl_vec   = (MODE != 0) ? ~in_vec : in_vec;
  assign unknown_in = $isunknown(in_vec);

  assign clr_en  = clr && (state_q == S_IDLE);
  // The change-only compare is case inequality, so a move to or from X counts as a change.
  assign eval_en = (state_q == S_IDLE) && sample_en && !clr &&
                   ((CHANGE_ONLY == 0) || !hist_q || (expr_d !== expr_q));
  assign accept  = (state_q == S_DUMP) && rd_valid_q && rd_ready;

  always_comb begin
    bin_hit       = '0;
    bin_hit[NB-1] = 1'b1;
    if (unknown_in) begin
      bin_hit[N_IN+1] = 1'b1;
    end else if (ctrl_vec == '0) begin
      bin_hit[N_IN] = 1'b1;
    end else if ($onehot(ctrl_vec)) begin
      // A single controlling bit lands directly on its own bin.
      bin_hit[N_IN-1:0] = ctrl_vec;
    end
  end

  // Dump FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      dump_done_q <= 1'b0;
    end else begin
      dump_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dump_req) begin
            state_q    <= S_DUMP;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_idx_q   <= '0;
          end
        end
        S_DUMP: begin
          if (rd_ready) begin
            if (rd_idx_q == IDX_W'(NB - 1)) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              rd_valid_q  <= 1'b0;
              rd_idx_q    <= '0;
              dump_done_q <= 1'b1;
            end else begin
              rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Counters and the sticky saturation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      sat_q <= 1'b0;
    end else if (clr_en) begin
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      sat_q <= 1'b0;
    end else begin
      // Increments happen only in IDLE and read-clears only in DUMP, so they never collide.
      for (int b = 0; b < NB; b++) begin
        if (eval_en && bin_hit[b]) begin
          if (&cnt_q[b]) sat_q <= 1'b1;
          else           cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end else if (accept && (CLEAR_ON_DUMP != 0) && (rd_idx_q == IDX_W'(b))) begin
          cnt_q[b] <= '0;
        end
      end
    end
  end

  // Last evaluated result and change-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expr_q <= 1'b0;
      hist_q <= 1'b0;
    end else if (clr_en) begin
      hist_q <= 1'b0;
    end else if (eval_en) begin
      expr_q <= expr_d;
      hist_q <= 1'b1;
    end
  end

  assign expr_out  = expr_q;
  assign busy      = busy_q;
  assign rd_valid  = rd_valid_q;
  assign rd_idx    = rd_idx_q;
  assign rd_data   = rd_valid_q ? cnt_q[rd_idx_q] : '0;
  assign dump_done = dump_done_q;
  assign sat_flag  = sat_q;
  assign dbg_state = (state_q == S_DUMP);

endmodule

// File: doc/expr_cov_monitor.md
Name: expr_cov_monitor

Overview:
- Parametrised hardware expression/condition coverage collector for an N-input reduction expression (OR or AND).
- Samples the input vector, evaluates the expression and classifies each evaluation as one of:
  - a single-input determining hit (focused-expression row),
  - the all-non-controlling row,
  - an unknown (X/Z) evaluation.
- Saturating counters hold the results and are drained through a valid/ready dump port.
- Sits beside the design under test in simulation benches and feeds the coverage database writer.

Parameters:
- N_IN, default 2: number of expression inputs; legal range 2..16.
- MODE, default 0: 0 = OR reduction (controlling value 1); 1 = AND reduction (controlling value 0).
- CNT_W, default 16: width of each counter.
- CHANGE_ONLY, default 1:
  - 1 = count only when the expression result changes (event-triggered evaluation);
  - 0 = count every enabled sample.
- CLEAR_ON_DUMP, default 0: 1 = each counter is zeroed in the cycle it is read out.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sample_en, input, 1: qualifies in_vec this cycle.
- in_vec, input, N_IN: expression inputs, 4-state.
- clr, input, 1: synchronous clear of all counters, sat_flag and the change-detect history.
- dump_req, input, 1: pulse that starts a counter dump.
- expr_out, output, 1: registered result of the last evaluated sample (4-state).
- busy, output, 1: high while in DUMP.
- rd_valid, output, 1: rd_idx/rd_data are valid.
- rd_ready, input, 1: consumer accepts the current beat.
- rd_idx, output, clog2(N_IN+3): bin index of the current beat.
- rd_data, output, CNT_W: counter value of the current beat.
- dump_done, output, 1: one-cycle pulse after the last beat is accepted.
- sat_flag, output, 1: sticky; set when any counter saturates.

Behaviour:
- Reset values: all counters 0; expr_out 0; busy 0; rd_valid 0; rd_idx 0; rd_data 0; dump_done 0; sat_flag 0; history invalid; state IDLE.
- Reset is honoured mid-dump: the dump is aborted and no dump_done is issued.
- Bins:
  - 0..N_IN-1: input i determining, i.e. in_vec[i] equals the controlling value and every other bit equals the non-controlling value.
  - N_IN: all bits non-controlling.
  - N_IN+1: unknown, i.e. any bit X/Z, detected with a 4-state compare.
  - N_IN+2: total evaluations.
- Classification: other known patterns (two or more controlling bits) increment only bin N_IN+2.
- Evaluation condition:
  - state == IDLE, sample_en == 1 and clr == 0;
  - and, if CHANGE_ONLY, either the history is invalid or the new result differs from expr_out under a 4-state (case-equality) compare.
- On evaluation:
  - the classified bin and bin N_IN+2 increment;
  - expr_out and the history update.
- Latency: counters and expr_out reflect a sample on the edge following the sample cycle.
- Saturation: a counter at all-ones holds its value; an attempted increment at all-ones sets sat_flag.
- clr:
  - zeroes counters, clears sat_flag and invalidates the history;
  - clr wins over a same-cycle sample;
  - clr is ignored while busy.
- FSM IDLE:
  - dump_req moves to DUMP with rd_idx = 0, rd_valid = 1 and busy = 1 on the next cycle;
  - dump_req and a sample in the same cycle: the sample is counted first, then DUMP is entered.
- FSM DUMP:
  - rd_data always equals counter[rd_idx];
  - rd_idx, rd_data and rd_valid are held stable while rd_ready = 0;
  - on rd_valid && rd_ready: if CLEAR_ON_DUMP, that counter is zeroed; rd_idx advances;
  - after index N_IN+2 is accepted: rd_valid = 0, busy = 0, dump_done pulses one cycle, return to IDLE.
- DUMP boundary rules:
  - samples are dropped and dump_req is ignored;
  - back-to-back dumps are legal from the cycle after dump_done.
- X on the control inputs (sample_en, clr, dump_req, rd_ready) is outside the contract.

Test Plan:
1. N_IN=2, MODE=0, CHANGE_ONLY=1; samples 00, 10, 00, X0 on consecutive cycles, then dump with rd_ready=1 → beats (0:1, 1:0, 2:2, 3:1, 4:4); expr_out ends X; dump_done one cycle after beat 4.
2. Same config; samples 10, 10, 11, 01 → only the first evaluates (result stays 1) → bin0=1, bin4=1, all other bins 0.
3. CHANGE_ONLY=0, MODE=1, N_IN=3; samples 011, 111, 101, 001 → bin0=1, bin3=1, bin1=1, bin5=4; bin2=0; bin4=0.
4. CNT_W=2, CHANGE_ONLY=0; 5 samples of 10 → bin0=3, bin4=3, sat_flag=1; then clr → all bins 0 and sat_flag=0.
5. Dump with rd_ready toggling 1,0,0,1…:
   - beats are held stable during stalls; samples during busy are not counted;
   - with CLEAR_ON_DUMP=1 a second dump returns all zeros.
6. Assert rst at beat 2 of a dump → rd_valid=0 and busy=0 immediately, no dump_done, counters 0; a sample and dump_req in the same IDLE cycle → that sample is included in the dump.
